alu_mul_sequencer: RTL

Iterative shift-add multiplier that sits on the initiator side of the datapath ALU. It drives the ALU's two data inputs and 4-bit opcode, and consumes the ALU's combinational result. No adder of its own: every partial-product accumulation uses the ALU add opcode. Produces the low WIDTH bits of operand_a × operand_b under a start/busy/done handshake; used by the multi-cycle MUL path.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 27 ++
 rtl/alu_mul_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and multiplier sequencer states, so the ALU control
// path and the MUL sequencer agree on opcode values.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Datapath ALU: purely combinational; unknown opcodes (including NOP) return 0.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]    input_data_1,
    input  logic [WIDTH-1:0]    input_data_2,
    input  logic [ALU_OP_W-1:0] input_opcode,
    output logic [WIDTH-1:0]    output_data,
    output logic [WIDTH-1:0]    output_zero
);

    always_comb begin
        output_data = '0;
        case (input_opcode)
            ALU_ADD: output_data = input_data_1 + input_data_2;
            ALU_SUB: output_data = input_data_1 - input_data_2;
            ALU_AND: output_data = input_data_1 & input_data_2;
            ALU_OR:  output_data = input_data_1 | input_data_2;
            default: output_data = '0;
        endcase
    end

    assign output_zero = WIDTH'(output_data == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier that borrows the datapath ALU for every
// partial-product addition; yields the low WIDTH bits of a*b.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned          WIDTH      = 64,
    parameter logic [ALU_OP_W-1:0]  ADD_OPCODE = ALU_ADD,
    parameter logic [ALU_OP_W-1:0]  NOP_OPCODE = ALU_NOP
) (
    input  logic                input_clk,
    input  logic                input_rst_n,
    input  logic                input_start,
    input  logic [WIDTH-1:0]    input_operand_a,
    input  logic [WIDTH-1:0]    input_operand_b,
    output logic                output_busy,
    output logic                output_done,
    output logic [WIDTH-1:0]    output_result,
    output logic                output_result_zero,
    output logic [WIDTH-1:0]    output_alu_data_1,
    output logic [WIDTH-1:0]    output_alu_data_2,
    output logic [ALU_OP_W-1:0] output_alu_opcode,
    input  logic [WIDTH-1:0]    input_alu_data,
    input  logic [WIDTH-1:0]    input_alu_zero
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_zero_q, result_zero_d;

    // The ALU zero flag carries nothing the sequencer needs.
    logic unused_alu_zero;
    assign unused_alu_zero = |input_alu_zero;

    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            state_q       <= SEQ_IDLE;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
        end
    end

    // Next state plus ALU drive; the ALU is only asked to add on a set multiplier bit.
    always_comb begin
        state_d           = state_q;
        acc_d             = acc_q;
        mcand_d           = mcand_q;
        mplier_d          = mplier_q;
        result_d          = result_q;
        result_zero_d     = result_zero_q;
        output_alu_data_1 = '0;
        output_alu_data_2 = '0;
        output_alu_opcode = NOP_OPCODE;

        case (state_q)
            SEQ_IDLE: begin
                if (input_start) begin
                    acc_d    = '0;
                    mcand_d  = input_operand_a;
                    mplier_d = input_operand_b;
                    state_d  = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (mplier_q != '0) begin
                    if (mplier_q[0]) begin
                        output_alu_data_1 = acc_q;
                        output_alu_data_2 = mcand_q;
                        output_alu_opcode = ADD_OPCODE;
                        acc_d             = input_alu_data;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    result_d      = acc_q;
                    result_zero_d = (acc_q == '0);
                    state_d       = SEQ_DONE;
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
    end

    assign output_busy        = (state_q != SEQ_IDLE);
    assign output_done        = (state_q == SEQ_DONE);
    assign output_result      = result_q;
    assign output_result_zero = result_zero_q;

endmodule
